// File: rtl/clk_gen.sv
// -----------------------------------------------------------------------------
// clk_gen - synchronous programmable clock generator
//
// Builds clk_out from the reference clock by integer division. Each generated
// period is P reference cycles: high for ceil(P/2) and low for floor(P/2).
// A new period value always waits for a period boundary, so the output never
// has a partial phase. Dropping en always lets the current period finish.
//
// Ports
//   clk        in   reference clock; all logic runs on its rising edge
//   rst        in   active-low synchronous reset
//   en         in   run request
//   div        in   requested period in reference cycles (values < 2 become 2)
//   div_load   in   one-cycle pulse that captures div
//   clk_out    out  generated clock (registered)
//   rise_stb   out  high for the reference cycle right after clk_out rises
//   fall_stb   out  high for the reference cycle right after clk_out falls
//   running    out  high while the generator is in RUN
//   cycle_cnt  out  number of generated rising edges since reset (wraps)
// -----------------------------------------------------------------------------
module clk_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             div_load,
    output logic             clk_out,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_cnt;      // position inside the current period
    logic [DIV_W-1:0] r_period;   // period P in use for the current period
    logic [DIV_W-1:0] r_pending;  // period to adopt at the next boundary

    logic [DIV_W-1:0] w_div_clamped;
    logic [DIV_W-1:0] w_high;
    logic [DIV_W-1:0] w_next_period;

    // A period of 0 or 1 cannot produce both phases, so it is raised to 2.
    assign w_div_clamped = (div < DIV_W'(2)) ? DIV_W'(2) : div;

    // High phase length: ceil(P/2).
    assign w_high = r_period - (r_period >> 1);

    // A load arriving on the very edge that starts a period wins over the
    // older pending value, so it takes effect without a one-period delay.
    assign w_next_period = div_load ? w_div_clamped : r_pending;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_period  <= DIV_W'(DEFAULT_DIV);
            r_pending <= DIV_W'(DEFAULT_DIV);
            clk_out   <= 1'b0;
            rise_stb  <= 1'b0;
            fall_stb  <= 1'b0;
            running   <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;

            if (div_load) begin
                r_pending <= w_div_clamped;
            end

            case (r_state)
                IDLE: begin
                    clk_out <= 1'b0;
                    if (div_load) begin
                        r_period <= w_div_clamped;
                    end
                    if (en) begin
                        r_state   <= RUN;
                        r_cnt     <= '0;
                        r_period  <= w_next_period;
                        clk_out   <= 1'b1;
                        rise_stb  <= 1'b1;
                        running   <= 1'b1;
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end

                RUN: begin
                    if (r_cnt == r_period - DIV_W'(1)) begin
                        // Period boundary: either start a new period or stop
                        // with clk_out already low after the full low phase.
                        r_cnt <= '0;
                        if (en) begin
                            r_period  <= w_next_period;
                            clk_out   <= 1'b1;
                            rise_stb  <= 1'b1;
                            cycle_cnt <= cycle_cnt + CNT_W'(1);
                        end else begin
                            r_state <= IDLE;
                            running <= 1'b0;
                            clk_out <= 1'b0;
                        end
                    end else if (r_cnt == w_high - DIV_W'(1)) begin
                        clk_out  <= 1'b0;
                        fall_stb <= 1'b1;
                        r_cnt    <= r_cnt + DIV_W'(1);
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_gen - directed self-checking bench for clk_gen
//
// A vector table covers reset, the default period and a period of 5. Per-edge
// pattern strings cover the multi-cycle cases: period changes mid-period and
// at the boundary, glitch-free disable, clamping of div, reset in the high
// phase and counter wrap on a 4-bit counter instance.
// Pattern letters: R rise edge, H high, F fall edge, L low, I idle/reset.
// -----------------------------------------------------------------------------
module tb_clk_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  div;
    logic        div_load;

    logic        clk_out, rise_stb, fall_stb, running;
    logic [31:0] cycle_cnt;

    logic        c4_out, c4_rise, c4_fall, c4_running;
    logic [3:0]  c4_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cyc  = 0;

    always #5 clk = ~clk;

    clk_gen #(.DIV_W(8), .DEFAULT_DIV(2), .CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div       (div),
        .div_load  (div_load),
        .clk_out   (clk_out),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .running   (running),
        .cycle_cnt (cycle_cnt)
    );

    clk_gen #(.DIV_W(8), .DEFAULT_DIV(2), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div       (div),
        .div_load  (div_load),
        .clk_out   (c4_out),
        .rise_stb  (c4_rise),
        .fall_stb  (c4_fall),
        .running   (c4_running),
        .cycle_cnt (c4_cnt)
    );

    // {rst, en, div, div_load} applied for one edge, then the expected
    // {clk_out, rise_stb, fall_stb, running} and cycle_cnt after that edge.
    typedef struct {
        logic        rst_n;
        logic        en;
        logic [7:0]  div;
        logic        ld;
        logic [3:0]  flags;
        int unsigned cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp_flags, input int unsigned exp_c);
        n_checks++;
        if ({clk_out, rise_stb, fall_stb, running} !== exp_flags) begin
            n_fail++;
            $display("FAIL %s flags {clk_out,rise,fall,running}: got %b expected %b",
                     name, {clk_out, rise_stb, fall_stb, running}, exp_flags);
        end
        n_checks++;
        if (cycle_cnt !== 32'(exp_c)) begin
            n_fail++;
            $display("FAIL %s cycle_cnt: got %0d expected %0d", name, cycle_cnt, exp_c);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] exp_c);
        n_checks++;
        if (c4_cnt !== exp_c) begin
            n_fail++;
            $display("FAIL %s cycle_cnt(CNT_W=4): got %0d expected %0d", name, c4_cnt, exp_c);
        end
    endtask

    // Runs one edge per pattern letter with the inputs currently applied.
    task automatic seq(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            logic [3:0] e;
            byte        c;
            c = pat[i];
            step();
            case (c)
                "R": begin e = 4'b1101; exp_cyc++; end
                "H": e = 4'b1001;
                "F": e = 4'b0011;
                "L": e = 4'b0001;
                default: e = 4'b0000;
            endcase
            $display("%s[%0d] exp=%s clk_out=%b rise=%b fall=%b running=%b cycle_cnt=%0d",
                     tag, i, string'(c), clk_out, rise_stb, fall_stb, running, cycle_cnt);
            chk($sformatf("%s[%0d]", tag, i), e, exp_cyc);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [7:0] d,
                                input logic l, input logic [3:0] f, input int unsigned c);
        vec_t v;
        v.rst_n = r; v.en = e; v.div = d; v.ld = l; v.flags = f; v.cyc = c;
        return v;
    endfunction

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        div      = 8'd0;
        div_load = 1'b0;

        // ---------------- vector table ----------------
        // Reset held 3 edges, then idle for 10 edges.
        for (int i = 0; i < 3; i++)  vecs.push_back(mk(1'b0, 1'b0, 8'd0, 1'b0, 4'b0000, 0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 4'b0000, 0));
        // Default P=2: rise on odd edges, fall on even edges, 10 rises in 20 edges.
        for (int i = 1; i <= 20; i++) begin
            if (i % 2 == 1) vecs.push_back(mk(1'b1, 1'b1, 8'd0, 1'b0, 4'b1101, (i + 1) / 2));
            else            vecs.push_back(mk(1'b1, 1'b1, 8'd0, 1'b0, 4'b0011, i / 2));
        end
        // en dropped: the boundary returns to idle with clk_out low.
        vecs.push_back(mk(1'b1, 1'b0, 8'd0, 1'b0, 4'b0000, 10));
        // Load 5 in idle, then run two periods: high 3 / low 2.
        vecs.push_back(mk(1'b1, 1'b0, 8'd5, 1'b1, 4'b0000, 10));
        for (int j = 0; j < 10; j++) begin
            logic [3:0] f;
            case (j % 5)
                0:       f = 4'b1101;
                1, 2:    f = 4'b1001;
                3:       f = 4'b0011;
                default: f = 4'b0001;
            endcase
            vecs.push_back(mk(1'b1, 1'b1, 8'd5, 1'b0, f, 11 + j / 5));
        end
        vecs.push_back(mk(1'b1, 1'b0, 8'd5, 1'b0, 4'b0000, 12));

        foreach (vecs[i]) begin
            rst      = vecs[i].rst_n;
            en       = vecs[i].en;
            div      = vecs[i].div;
            div_load = vecs[i].ld;
            step();
            $display("vec%0d rst=%b en=%b div=%0d ld=%b -> clk_out=%b rise=%b fall=%b running=%b cycle_cnt=%0d",
                     i, rst, en, div, div_load, clk_out, rise_stb, fall_stb, running, cycle_cnt);
            chk($sformatf("vec%0d", i), vecs[i].flags, vecs[i].cyc);
        end
        exp_cyc = 12;

        // ---------------- period change mid-period (P=4 -> 6) ----------------
        rst = 1'b1; en = 1'b0; div = 8'd4; div_load = 1'b1;
        seq("ld4", "I");
        div_load = 1'b0; en = 1'b1;
        seq("p4a", "RH");
        div = 8'd6; div_load = 1'b1;
        seq("p4ld", "F");
        div_load = 1'b0;
        seq("p4b", "LRHHFLL");
        seq("p6a", "R");
        div = 8'd4; div_load = 1'b1;
        seq("p6ld", "H");
        div_load = 1'b0;
        seq("p6b", "HFLL");
        seq("p4c", "RHFL");
        // Load coinciding with the boundary applies from that boundary.
        div = 8'd6; div_load = 1'b1;
        seq("bnd", "R");
        div_load = 1'b0;
        seq("p6c", "HHFLLR");

        // ---------------- glitch-free disable at P=6 ----------------
        en = 1'b0;
        seq("dis", "HHFLLII");
        en = 1'b1;
        seq("reen", "R");
        en = 1'b0;
        seq("glitch", "HH");
        en = 1'b1;
        seq("cont", "FLLR");

        // ---------------- clamping of div=0 and div=1 ----------------
        div = 8'd0; div_load = 1'b1;
        seq("ld0", "H");
        div_load = 1'b0;
        seq("p2a", "HFLLRFRF");
        div = 8'd1; div_load = 1'b1;
        seq("ld1", "R");
        div_load = 1'b0;
        seq("p2b", "FRF");

        // ---------------- reset in the high phase ----------------
        div = 8'd6; div_load = 1'b1;
        seq("ld6", "R");
        div_load = 1'b0;
        seq("hi", "H");
        rst = 1'b0;
        exp_cyc = 0;
        seq("rst", "I");
        rst = 1'b1;
        // Reset restores P=2.
        seq("post", "RFRF");

        // ---------------- counter wrap on the CNT_W=4 instance ----------------
        rst = 1'b0;
        exp_cyc = 0;
        seq("rst2", "I");
        chk4("wrap_reset", 4'd0);
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            seq($sformatf("wrap%0d", i), "RF");
            if (i == 15) chk4("wrap16", 4'd0);
        end
        chk4("wrap17", 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_gen.md
Name: clk_gen

Overview:
- Synchronous programmable clock generator; derives the system clock `clk_out` from the reference clock `clk` by integer division.
- Provides rise/fall strobes in the reference domain, a run status flag and a count of generated cycles.
- Sits at the top of the design; the generated clock and strobes feed the CPU, DMA and RAM blocks.

Parameters:
- DIV_W, 8, width of the period value (reference cycles per generated period).
- DEFAULT_DIV, 2, period loaded at reset; must be at least 2.
- CNT_W, 32, width of the generated-cycle counter.

Ports:
- clk  in  1  reference clock; all logic on its rising edge.
- rst  in  1  active-low synchronous reset.
- en  in  1  run request.
- div  in  DIV_W  requested period in reference cycles.
- div_load  in  1  one-cycle pulse that captures `div`.
- clk_out  out  1  generated clock, registered.
- rise_stb  out  1  high for the one reference cycle in which `clk_out` has just risen.
- fall_stb  out  1  high for the one reference cycle in which `clk_out` has just fallen.
- running  out  1  high while in RUN.
- cycle_cnt  out  CNT_W  number of generated rising edges since reset; wraps.

Behaviour:
- Interface fact: one clock; reset is synchronous and active-low (`clk`, `rst`).
- Reset (rst=0 sampled on a `clk` edge) drives:
  - state=IDLE, cnt=0, clk_out=0, rise_stb=0, fall_stb=0, running=0, cycle_cnt=0;
  - period P=DEFAULT_DIV and pending period=DEFAULT_DIV.
- Reset mid-operation forces `clk_out` low at that edge, even if this truncates a high phase; a runt pulse is permitted.
- Strobes default to 0 on every edge unless set by a rule below.
- Clamping: a captured `div` value below 2 is stored as 2. H = P − (P>>1), so the high phase is ceil(P/2) cycles and the low phase is floor(P/2).
- `div_load`:
  - writes `pending` on every edge where it is sampled high, in any state;
  - in IDLE, P is also updated on that same edge.
- IDLE:
  - `clk_out` is held at 0.
  - When en=1 is sampled: state→RUN, cnt←0, clk_out←1, rise_stb←1, cycle_cnt+1, running←1, P←pending (or the `div` being loaded on that same edge).
- RUN, evaluated in priority order each edge:
  - a) cnt==P−1 (period boundary):
    - if en=1: cnt←0, clk_out←1, rise_stb←1, cycle_cnt+1, P←pending. A `div_load` on this same edge bypasses `pending`, so its clamped value takes effect here.
    - if en=0: state→IDLE, running←0, cnt←0, `clk_out` stays 0.
  - b) cnt==H−1: clk_out←0, fall_stb←1, cnt+1.
  - c) otherwise cnt+1.
- Disable is glitch-free: deasserting `en` mid-period always completes the current period, including its full low phase. Re-asserting `en` before the boundary continues without a gap.
- Period changes never take effect mid-period in RUN; there are no partial phases.
- `cycle_cnt` wraps from 2^CNT_W−1 to 0.
- Latency: `clk_out` rises on the same edge that samples `en`=1 in IDLE.

Test Plan:
1. Reset with rst=0 for 3 cycles, then rst=1, en=0, 10 cycles: `clk_out`=0, `running`=0, `cycle_cnt`=0, no strobes.
2. Defaults (P=2), en=1 for 20 cycles:
   - `clk_out` toggles every reference cycle, starting high on the edge that samples en;
   - `rise_stb` and `fall_stb` alternate;
   - `cycle_cnt`=10 after 20 edges.
3. div=5 with div_load in IDLE, then en=1:
   - pattern repeats as high 3 / low 2;
   - `fall_stb` pulses 3 cycles after each `rise_stb`.
4. Running at P=4, pulse div_load with div=6 two cycles after a rise:
   - the current period completes as high 2 / low 2;
   - the next period is high 3 / low 3.
   - Repeat with div_load coinciding with the boundary: P=6 applies from that same boundary.
5. Running at P=6, drop en during the high phase:
   - high 3 / low 3 completes, then `clk_out` stays 0 and `running` drops at the boundary;
   - re-raise en → immediate rise.
   - Also load div=0 or div=1 → behaves as P=2.
6. Mid-high-phase rst=0 → next edge `clk_out`=0 and all counters 0. Separately, with CNT_W=4, 17 rises → `cycle_cnt`=1.
